// File: rtl/ysyx_00000000_rd_arbiter.sv
// Round-robin arbiter that funnels NUM_RD read requesters onto one AXI4 read master
// or a local-device port, with one transaction in flight and pass-through read data.
module ysyx_00000000_rd_arbiter #(
  parameter int          NUM_RD   = 2,
  parameter logic [31:0] LOC_BASE = 32'h0200_0000,
  parameter logic [31:0] LOC_MASK = 32'hFFFF_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_RD-1:0]    req_arvalid,
  input  logic [NUM_RD*32-1:0] req_araddr,
  input  logic [NUM_RD*3-1:0]  req_arsize,
  input  logic [NUM_RD*8-1:0]  req_arlen,
  output logic [NUM_RD-1:0]    req_arready,
  output logic [NUM_RD-1:0]    req_rvalid,
  output logic [31:0]          req_rdata,
  output logic [1:0]           req_rresp,
  output logic                 req_rlast,
  input  logic [NUM_RD-1:0]    req_rready,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  output logic [31:0]          m_araddr,
  output logic [7:0]           m_arlen,
  output logic [2:0]           m_arsize,
  output logic [3:0]           m_arid,
  output logic [1:0]           m_arburst,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  input  logic [31:0]          m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rlast,
  input  logic [3:0]           m_rid,
  output logic                 loc_arvalid,
  input  logic                 loc_arready,
  output logic [31:0]          loc_araddr,
  input  logic                 loc_rvalid,
  output logic                 loc_rready,
  input  logic [31:0]          loc_rdata
);

  localparam int IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state, state_next;
  logic [IW-1:0] last_grant, grant, pick, cand;
  logic          found;
  logic [31:0]   addr_q;
  logic [2:0]    size_q;
  logic [7:0]    len_q;
  logic          is_local;
  logic [8:0]    beat;
  logic          beat_hs, last_beat;
  logic [31:0]   pick_addr;
  logic          unused_rid;

  assign unused_rid = ^m_rid;
  assign pick_addr  = req_araddr[32*pick +: 32];

  assign m_araddr   = addr_q;
  assign loc_araddr = addr_q;
  assign m_arlen    = len_q;
  assign m_arsize   = size_q;
  assign m_arid     = 4'(grant);
  assign m_arburst  = 2'b01;

  // Round-robin search starting just after the most recent grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_RD; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_RD);
      if (!found && req_arvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_arready = '0;
    m_arvalid   = 1'b0;
    loc_arvalid = 1'b0;
    m_rready    = 1'b0;
    loc_rready  = 1'b0;
    req_rvalid  = '0;
    req_rdata   = '0;
    req_rresp   = 2'b00;
    req_rlast   = 1'b0;
    beat_hs     = 1'b0;
    last_beat   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          req_arready = NUM_RD'(1) << pick;
          state_next  = ADDR;
        end
      end
      ADDR: begin
        if (is_local) begin
          loc_arvalid = 1'b1;
          if (loc_arready) state_next = DATA;
        end else begin
          m_arvalid = 1'b1;
          if (m_arready) state_next = DATA;
        end
      end
      DATA: begin
        if (is_local) begin
          req_rvalid = NUM_RD'(loc_rvalid) << grant;
          loc_rready = req_rready[grant];
          req_rdata  = loc_rdata;
          req_rlast  = 1'b1;
          if (loc_rvalid && req_rready[grant]) state_next = IDLE;
        end else begin
          req_rvalid = NUM_RD'(m_rvalid) << grant;
          m_rready   = req_rready[grant];
          req_rdata  = m_rdata;
          last_beat  = (beat == {1'b0, len_q});
          req_rlast  = last_beat;
          // A slave rlast that disagrees with our own beat count is reported as SLVERR.
          req_rresp  = (last_beat != m_rlast) ? 2'b10 : m_rresp;
          beat_hs    = m_rvalid && req_rready[grant];
          if (beat_hs && last_beat) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= IW'(NUM_RD - 1);
      grant      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      len_q      <= '0;
      is_local   <= 1'b0;
      beat       <= '0;
    end else begin
      if (state == IDLE && found) begin
        last_grant <= pick;
        grant      <= pick;
        addr_q     <= pick_addr;
        size_q     <= req_arsize[3*pick +: 3];
        len_q      <= req_arlen[8*pick +: 8];
        is_local   <= (pick_addr & LOC_MASK) == LOC_BASE;
        beat       <= '0;
      end
      if (beat_hs) beat <= last_beat ? 9'd0 : beat + 9'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_00000000_rd_arbiter.sv
// Scoreboard bench for the read arbiter: directed transactions push expected AR and R
// records, and a monitor pops and compares them on every observed handshake.
module tb_ysyx_00000000_rd_arbiter;

  localparam int NUM_RD = 2;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_RD-1:0]    req_arvalid;
  logic [NUM_RD*32-1:0] req_araddr;
  logic [NUM_RD*3-1:0]  req_arsize;
  logic [NUM_RD*8-1:0]  req_arlen;
  logic [NUM_RD-1:0]    req_arready;
  logic [NUM_RD-1:0]    req_rvalid;
  logic [31:0]          req_rdata;
  logic [1:0]           req_rresp;
  logic                 req_rlast;
  logic [NUM_RD-1:0]    req_rready;
  logic                 m_arvalid, m_arready;
  logic [31:0]          m_araddr;
  logic [7:0]           m_arlen;
  logic [2:0]           m_arsize;
  logic [3:0]           m_arid;
  logic [1:0]           m_arburst;
  logic                 m_rvalid, m_rready;
  logic [31:0]          m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast;
  logic [3:0]           m_rid;
  logic                 loc_arvalid, loc_arready;
  logic [31:0]          loc_araddr;
  logic                 loc_rvalid, loc_rready;
  logic [31:0]          loc_rdata;

  ysyx_00000000_rd_arbiter #(.NUM_RD(NUM_RD)) dut (
    .clock(clock), .reset(reset),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arsize(req_arsize),
    .req_arlen(req_arlen), .req_arready(req_arready), .req_rvalid(req_rvalid),
    .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
    .req_rready(req_rready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arid(m_arid), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .loc_arvalid(loc_arvalid), .loc_arready(loc_arready), .loc_araddr(loc_araddr),
    .loc_rvalid(loc_rvalid), .loc_rready(loc_rready), .loc_rdata(loc_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_local;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } ar_exp_t;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  int      tests_run    = 0;
  int      tests_failed = 0;
  int      m_ar_count   = 0;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic push_ar(input logic is_local, input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id);
    ar_exp_t e;
    e.is_local = is_local; e.addr = addr; e.len = len; e.id = id;
    ar_q.push_back(e);
  endtask

  task automatic push_r(input logic [1:0] who, input logic [31:0] data, input logic [1:0] resp,
                        input logic last);
    r_exp_t e;
    e.who = who; e.data = data; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  // Monitor: every address or data handshake must match the next queued expectation.
  initial begin
    ar_exp_t ea;
    r_exp_t  er;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if ((m_arvalid && m_arready) || (loc_arvalid && loc_arready)) begin
          if (m_arvalid) m_ar_count++;
          check_output("ar_expected", ar_q.size() != 0, 1);
          if (ar_q.size() != 0) begin
            ea = ar_q.pop_front();
            check_output("ar_channel", {m_arvalid, loc_arvalid}, {~ea.is_local, ea.is_local});
            check_output("ar_addr", ea.is_local ? loc_araddr : m_araddr, ea.addr);
            check_output("ar_len", m_arlen, ea.len);
            check_output("ar_id", m_arid, ea.id);
            check_output("ar_size", m_arsize, 3'd2);
            check_output("ar_burst", m_arburst, 2'b01);
          end
        end
        if ((req_rvalid & req_rready) != '0) begin
          check_output("r_expected", r_q.size() != 0, 1);
          if (r_q.size() != 0) begin
            er = r_q.pop_front();
            check_output("r_valid", req_rvalid, er.who);
            check_output("r_data", req_rdata, er.data);
            check_output("r_resp", req_rresp, er.resp);
            check_output("r_last", req_rlast, er.last);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input int who, input logic [31:0] addr, input logic [7:0] len);
    req_araddr[32*who +: 32] = addr;
    req_arlen[8*who +: 8]    = len;
    req_arsize[3*who +: 3]   = 3'd2;
    req_arvalid[who]         = 1'b1;
  endtask

  // Waits for the grant, checks it is one-hot to 'who', and checks the t+1 address valid.
  task automatic wait_grant(input int who, input logic keep, input logic is_local);
    logic [1:0] want;
    logic       seen;
    want = 2'b01 << who;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clock);
      if (req_arready != '0) seen = 1'b1;
      else tick();
    end
    check_output("grant_seen", seen, 1);
    if (seen) begin
      check_output("arready_onehot", req_arready, want);
      tick();
      if (!keep) req_arvalid[who] = 1'b0;
      @(negedge clock);
      check_output("addr_valid_t1", {m_arvalid, loc_arvalid}, is_local ? 2'b01 : 2'b10);
      tick();
    end
  endtask

  task automatic send_beats(input int who, input int n, input int last_idx, input logic [31:0] base,
                            input logic [1:0] resp, input int stall_beat, input int stall_len);
    logic ok;
    for (int b = 0; b < n; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = base + b;
      m_rlast  = (b == last_idx);
      m_rresp  = resp;
      if (b == stall_beat) begin
        req_rready[who] = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clock);
          check_output("stall_m_rready", m_rready, 0);
          check_output("stall_rvalid", req_rvalid, 2'b01 << who);
          check_output("stall_rdata", req_rdata, base + b);
          tick();
        end
        req_rready[who] = 1'b1;
      end
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
        @(negedge clock);
        if (m_rvalid && m_rready) ok = 1'b1;
        else tick();
      end
      check_output("beat_handshake", ok, 1);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic send_local(input logic [31:0] data);
    logic ok;
    loc_rvalid = 1'b1;
    loc_rdata  = data;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clock);
      if (loc_rready) ok = 1'b1;
      else tick();
    end
    check_output("local_handshake", ok, 1);
    tick();
    loc_rvalid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int saved_count;
    req_arvalid = '0; req_araddr = '0; req_arsize = '0; req_arlen = '0; req_rready = 2'b11;
    m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    loc_arready = 1'b1; loc_rvalid = 1'b0; loc_rdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    check_output("reset_arready", req_arready, 0);
    check_output("reset_m_arvalid", m_arvalid, 0);
    check_output("reset_loc_arvalid", loc_arvalid, 0);
    check_output("reset_m_rready", m_rready, 0);
    check_output("reset_loc_rready", loc_rready, 0);
    check_output("reset_rvalid", req_rvalid, 0);
    check_output("reset_araddr", m_araddr, 0);
    tick();

    // Both request together: 0 wins first, then 1.
    apply_stimulus(0, 32'h8000_0000, 8'd0);
    apply_stimulus(1, 32'h8000_0100, 8'd0);
    push_ar(1'b0, 32'h8000_0000, 8'd0, 4'd0); push_r(2'b01, 32'hA000_0000, 2'b00, 1'b1);
    push_ar(1'b0, 32'h8000_0100, 8'd0, 4'd1); push_r(2'b10, 32'hA100_0000, 2'b01, 1'b1);
    wait_grant(0, 1'b0, 1'b0);
    send_beats(0, 1, 0, 32'hA000_0000, 2'b00, -1, 0);
    wait_grant(1, 1'b0, 1'b0);
    send_beats(1, 1, 0, 32'hA100_0000, 2'b01, -1, 0);

    // Requester 1 held, requester 0 re-pulsed: grants must alternate.
    apply_stimulus(1, 32'h8000_2000, 8'd0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 32'h8000_1000, 8'd0);
      push_ar(1'b0, 32'h8000_1000, 8'd0, 4'd0); push_r(2'b01, 32'hB000_0000 + i, 2'b00, 1'b1);
      wait_grant(0, 1'b0, 1'b0);
      req_arvalid[0] = 1'b1;
      send_beats(0, 1, 0, 32'hB000_0000 + i, 2'b00, -1, 0);
      push_ar(1'b0, 32'h8000_2000, 8'd0, 4'd1); push_r(2'b10, 32'hC000_0000 + i, 2'b00, 1'b1);
      wait_grant(1, 1'b1, 1'b0);
      send_beats(1, 1, 0, 32'hC000_0000 + i, 2'b00, -1, 0);
    end
    req_arvalid = '0;

    // Local window: single beat despite len=3, master channel untouched.
    saved_count = m_ar_count;
    apply_stimulus(0, 32'h0200_0048, 8'd3);
    push_ar(1'b1, 32'h0200_0048, 8'd3, 4'd0); push_r(2'b01, 32'hD00D_0001, 2'b00, 1'b1);
    wait_grant(0, 1'b0, 1'b1);
    send_local(32'hD00D_0001);
    check_output("local_no_m_ar", m_ar_count, saved_count);

    // Four-beat master burst with a two-cycle requester stall on beat 1.
    apply_stimulus(1, 32'h8000_0000, 8'd3);
    push_ar(1'b0, 32'h8000_0000, 8'd3, 4'd1);
    for (int b = 0; b < 4; b++) push_r(2'b10, 32'hE000_0000 + b, 2'b00, b == 3);
    wait_grant(1, 1'b0, 1'b0);
    send_beats(1, 4, 3, 32'hE000_0000, 2'b00, 1, 2);

    // Early slave rlast on beat 0 of a two-beat burst.
    apply_stimulus(0, 32'h8000_0300, 8'd1);
    push_ar(1'b0, 32'h8000_0300, 8'd1, 4'd0);
    push_r(2'b01, 32'hF000_0000, 2'b10, 1'b0);
    push_r(2'b01, 32'hF000_0001, 2'b10, 1'b1);
    wait_grant(0, 1'b0, 1'b0);
    send_beats(0, 2, 0, 32'hF000_0000, 2'b00, -1, 0);

    // Reset after one of four beats abandons the burst.
    apply_stimulus(0, 32'h8000_0400, 8'd3);
    push_ar(1'b0, 32'h8000_0400, 8'd3, 4'd0); push_r(2'b01, 32'h1234_0000, 2'b00, 1'b0);
    wait_grant(0, 1'b0, 1'b0);
    send_beats(0, 1, -1, 32'h1234_0000, 2'b00, -1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = 32'h5A5A_5A5A;
    @(negedge clock);
    check_output("abort_m_rready", m_rready, 0);
    check_output("abort_rvalid", req_rvalid, 0);
    check_output("abort_m_arvalid", m_arvalid, 0);
    check_output("abort_arready", req_arready, 0);
    check_output("abort_araddr", m_araddr, 0);
    tick();
    m_rvalid = 1'b0;
    apply_stimulus(1, 32'h8000_0500, 8'd0);
    push_ar(1'b0, 32'h8000_0500, 8'd0, 4'd1); push_r(2'b10, 32'h5555_0000, 2'b00, 1'b1);
    wait_grant(1, 1'b0, 1'b0);
    send_beats(1, 1, 0, 32'h5555_0000, 2'b00, -1, 0);

    repeat (3) tick();
    check_output("ar_queue_drained", ar_q.size(), 0);
    check_output("r_queue_drained", r_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
